// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap1_controller
// Description : SAP-1 controller-sequencer. A six-state ring counter, T1..T6,
//               steps through fetch and execute. The opcode and ring state
//               decode to the 12-bit active-low control word.
//               Optional macro: SAP1_SHORT_CYCLE_EN ends short instructions
//               early.
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic        hlt,
    output logic [5:0]  tstate
);

    // Ring bits sit at [5:0] so that tstate and hlt are taken straight from flops.
    localparam logic [6:0] c_S_T1   = 7'b000_0001;
    localparam logic [6:0] c_S_T2   = 7'b000_0010;
    localparam logic [6:0] c_S_T3   = 7'b000_0100;
    localparam logic [6:0] c_S_T4   = 7'b000_1000;
    localparam logic [6:0] c_S_T5   = 7'b001_0000;
    localparam logic [6:0] c_S_T6   = 7'b010_0000;
    localparam logic [6:0] c_S_HALT = 7'b100_0000;

    localparam logic [11:0] c_IDLE = 12'h3E3;

    logic [6:0]  r_state;
    logic [6:0]  w_next;
    logic [11:0] w_con;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_S_T1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_S_T1;
        case (r_state)
            c_S_T1: w_next = c_S_T2;
            c_S_T2: w_next = c_S_T3;
            c_S_T3: w_next = c_S_T4;
            c_S_T4: begin
                w_next = c_S_T5;
`ifdef SAP1_SHORT_CYCLE_EN
                if (opcode != OP_LDA && opcode != OP_ADD && opcode != OP_SUB) begin
                    w_next = c_S_T1;
                end
`endif
                if (opcode == OP_HLT) begin
                    w_next = c_S_HALT;
                end
            end
            c_S_T5: begin
                w_next = c_S_T6;
`ifdef SAP1_SHORT_CYCLE_EN
                if (opcode == OP_LDA) begin
                    w_next = c_S_T1;
                end
`endif
            end
            c_S_T6:   w_next = c_S_T1;
            c_S_HALT: w_next = c_S_HALT;
            default:  w_next = c_S_T1;
        endcase
    end

    // Undefined opcodes fall through to IDLE and behave as NOP.
    always_comb begin
        w_con = c_IDLE;
        if (!clr) begin
            case (r_state)
                c_S_T1: w_con = 12'h5E3;
                c_S_T2: w_con = 12'hBE3;
                c_S_T3: w_con = 12'h263;
                c_S_T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        w_con = 12'h1A3;
                    end else if (opcode == OP_OUT) begin
                        w_con = 12'h3F2;
                    end
                end
                c_S_T5: begin
                    if (opcode == OP_LDA) begin
                        w_con = 12'h2C3;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_con = 12'h2E1;
                    end
                end
                c_S_T6: begin
                    if (opcode == OP_ADD) begin
                        w_con = 12'h3C7;
                    end else if (opcode == OP_SUB) begin
                        w_con = 12'h3CF;
                    end
                end
                default: w_con = c_IDLE;
            endcase
        end
    end

    assign con    = w_con;
    assign hlt    = r_state[6];
    assign tstate = r_state[5:0];

endmodule
`default_nettype wire
